// File: rtl/tiny8_ctrl_gen2_pkg.sv
// Shared types for the tiny8 control unit: opcodes, ALU ops, fault codes
// and the packed datapath control word.
package tiny8_types;

    typedef enum logic [2:0] {
        op_ads = 3'd0,
        op_bpd = 3'd1,
        op_ldp = 3'd2,
        op_stp = 3'd3,
        op_hlt = 3'd4
    } tiny8_opcode;

    typedef enum logic [1:0] {
        alu_add = 2'd0,
        alu_sub = 2'd1,
        alu_mul = 2'd2,
        alu_dec = 2'd3
    } tiny8_aluop;

    typedef enum logic [1:0] {
        fault_none        = 2'd0,
        fault_mem_timeout = 2'd1,
        fault_illegal_op  = 2'd2
    } tiny8_fault_t;

    typedef struct packed {
        logic       load_pc;
        logic       load_acc;
        logic       load_rs;
        logic       load_rd;
        logic       load_ir;
        logic       load_mar;
        logic       load_mdr;
        logic       pcmux_sel;
        logic       regfilemux_sel;
        logic       alumux1_sel;
        logic       alumux2_sel;
        logic       mdrmux_sel;
        logic [1:0] marmux_sel;
        tiny8_aluop aluop;
        logic       mem_read;
        logic       mem_write;
    } tiny8_ctrl_t;

    localparam int WAIT_CNT_W = 8;

    function automatic tiny8_ctrl_t ctrl_default();
        tiny8_ctrl_t c;
        c       = '0;
        c.aluop = alu_add;
        return c;
    endfunction

endpackage

// File: rtl/tiny8_wait_timer.sv
// Memory wait timer: counts stalled cycles in a wait state and flags the
// last cycle allowed before a timeout.
import tiny8_types::*;

module tiny8_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    // high during the MAX_WAIT-th cycle of a wait; a response in that cycle still wins
    assign expired = (count == WAIT_CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/tiny8_ctrl_gen2.sv
// tiny8 multi-cycle control FSM with memory-timeout and illegal-opcode faults.
//   state   | meaning
//   IDLE    | waiting for run
//   FETCH1  | PC -> MAR, PC increment
//   FETCH2  | instruction read, waits on mem_resp
//   FETCH3  | MDR -> IR
//   DECODE  | opcode dispatch
//   ADS     | accumulate-multiply
//   BPD     | taken branch, decrement
//   LDP_1..3| load: address, read (waits), writeback
//   STP_1..3| store: address, data, write (waits)
//   HALT    | halted until a rising edge on run
//   FAULT   | sticky error, left only by reset
import tiny8_types::*;

module tiny8_ctrl_gen2 #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  tiny8_opcode      opcode,
    input  logic             branch_enable,
    input  logic             mem_resp,
    output logic             load_pc,
    output logic             load_acc,
    output logic             load_rs,
    output logic             load_rd,
    output logic             load_ir,
    output logic             load_mar,
    output logic             load_mdr,
    output logic             pcmux_sel,
    output logic             regfilemux_sel,
    output logic             alumux1_sel,
    output logic             alumux2_sel,
    output logic             mdrmux_sel,
    output logic [1:0]       marmux_sel,
    output tiny8_aluop       aluop,
    output logic             mem_read,
    output logic             mem_write,
    output logic             halted,
    output logic             fault,
    output tiny8_fault_t     fault_code,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE, FETCH1, FETCH2, FETCH3, DECODE, ADS, BPD,
        LDP_1, LDP_2, LDP_3, STP_1, STP_2, STP_3, HALT, FAULT
    } state_t;

    state_t       state;
    state_t       state_nxt;
    state_t       done_state;
    tiny8_ctrl_t  ctrl;
    tiny8_fault_t fault_code_nxt;
    logic         run_q;
    logic         retire;
    logic         in_wait;
    logic         expired;

    assign in_wait    = (state == FETCH2) || (state == LDP_2) || (state == STP_3);
    assign done_state = run ? FETCH1 : IDLE;

    tiny8_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_wait),
        .en      (in_wait && !mem_resp),
        .expired (expired)
    );

    function automatic tiny8_ctrl_t decode_ctrl(state_t s);
        tiny8_ctrl_t c;
        c = ctrl_default();
        case (s)
            FETCH1: begin c.marmux_sel = 2'd2; c.load_mar = 1'b1; c.load_pc = 1'b1; end
            FETCH2, LDP_2: begin c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1; end
            FETCH3: c.load_ir = 1'b1;
            ADS:    begin c.load_acc = 1'b1; c.aluop = alu_mul; c.alumux2_sel = 1'b1; end
            BPD:    begin c.load_pc = 1'b1; c.pcmux_sel = 1'b1; c.load_rs = 1'b1; c.aluop = alu_dec; end
            LDP_1, STP_1: c.load_mar = 1'b1;
            LDP_3: begin
                c.regfilemux_sel = 1'b1; c.load_rs = 1'b1; c.load_rd = 1'b1;
                c.alumux1_sel = 1'b1; c.aluop = alu_sub;
            end
            STP_2: begin c.load_mdr = 1'b1; c.load_rs = 1'b1; c.alumux1_sel = 1'b1; c.aluop = alu_sub; end
            STP_3: c.mem_write = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt      = state;
        fault_code_nxt = fault_none;
        retire         = 1'b0;
        case (state)
            IDLE:   if (run) state_nxt = FETCH1;
            FETCH1: state_nxt = FETCH2;
            FETCH2: begin
                if (mem_resp) state_nxt = FETCH3;
                else if (expired) begin state_nxt = FAULT; fault_code_nxt = fault_mem_timeout; end
            end
            FETCH3: state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    op_ads: state_nxt = ADS;
                    op_bpd: begin
                        if (branch_enable) state_nxt = BPD;
                        else begin state_nxt = done_state; retire = 1'b1; end
                    end
                    op_ldp: state_nxt = LDP_1;
                    op_stp: state_nxt = STP_1;
                    op_hlt: begin state_nxt = HALT; retire = 1'b1; end
                    default: begin state_nxt = FAULT; fault_code_nxt = fault_illegal_op; end
                endcase
            end
            ADS, BPD, LDP_3: begin state_nxt = done_state; retire = 1'b1; end
            LDP_1: state_nxt = LDP_2;
            LDP_2: begin
                if (mem_resp) state_nxt = LDP_3;
                else if (expired) begin state_nxt = FAULT; fault_code_nxt = fault_mem_timeout; end
            end
            STP_1: state_nxt = STP_2;
            STP_2: state_nxt = STP_3;
            STP_3: begin
                if (mem_resp) begin state_nxt = done_state; retire = 1'b1; end
                else if (expired) begin state_nxt = FAULT; fault_code_nxt = fault_mem_timeout; end
            end
            HALT:   if (run && !run_q) state_nxt = FETCH1;
            FAULT:  state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // controls are registered from the next state so they stay aligned with state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ctrl        <= ctrl_default();
            run_q       <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= fault_none;
            instr_count <= '0;
        end else begin
            state  <= state_nxt;
            ctrl   <= decode_ctrl(state_nxt);
            run_q  <= run;
            halted <= (state_nxt == HALT);
            if (retire) instr_count <= instr_count + CNT_W'(1);
            if (state_nxt == FAULT && state != FAULT) begin
                fault      <= 1'b1;
                fault_code <= fault_code_nxt;
            end
        end
    end

    assign load_pc        = ctrl.load_pc;
    assign load_acc       = ctrl.load_acc;
    assign load_rs        = ctrl.load_rs;
    assign load_rd        = ctrl.load_rd;
    assign load_ir        = ctrl.load_ir;
    assign load_mar       = ctrl.load_mar;
    assign load_mdr       = ctrl.load_mdr;
    assign pcmux_sel      = ctrl.pcmux_sel;
    assign regfilemux_sel = ctrl.regfilemux_sel;
    assign alumux1_sel    = ctrl.alumux1_sel;
    assign alumux2_sel    = ctrl.alumux2_sel;
    assign mdrmux_sel     = ctrl.mdrmux_sel;
    assign marmux_sel     = ctrl.marmux_sel;
    assign aluop          = ctrl.aluop;
    assign mem_read       = ctrl.mem_read;
    assign mem_write      = ctrl.mem_write;

endmodule

// File: tb/tb_tiny8_ctrl_gen2.sv
// Scoreboard bench for tiny8_ctrl_gen2 (MAX_WAIT=4, CNT_W=4): expected control
// snapshots are queued by the stimulus and popped by a negedge monitor.
import tiny8_types::*;

module tb_tiny8_ctrl_gen2;

    logic         clk;
    logic         rst_n;
    logic         run;
    tiny8_opcode  opcode;
    logic         branch_enable;
    logic         mem_resp;
    logic         load_pc, load_acc, load_rs, load_rd, load_ir, load_mar, load_mdr;
    logic         pcmux_sel, regfilemux_sel, alumux1_sel, alumux2_sel, mdrmux_sel;
    logic [1:0]   marmux_sel;
    tiny8_aluop   aluop;
    logic         mem_read, mem_write;
    logic         halted, fault;
    tiny8_fault_t fault_code;
    logic [3:0]   instr_count;

    tiny8_ctrl_gen2 #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .branch_enable(branch_enable), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_acc(load_acc), .load_rs(load_rs), .load_rd(load_rd),
        .load_ir(load_ir), .load_mar(load_mar), .load_mdr(load_mdr),
        .pcmux_sel(pcmux_sel), .regfilemux_sel(regfilemux_sel),
        .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .mdrmux_sel(mdrmux_sel),
        .marmux_sel(marmux_sel), .aluop(aluop), .mem_read(mem_read), .mem_write(mem_write),
        .halted(halted), .fault(fault), .fault_code(fault_code), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [26:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   dq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [18:0] act_cw;
    logic [26:0] act;
    assign act_cw = {load_pc, load_acc, load_rs, load_rd, load_ir, load_mar, load_mdr,
                     pcmux_sel, regfilemux_sel, alumux1_sel, alumux2_sel, mdrmux_sel,
                     marmux_sel, aluop, mem_read, mem_write};
    assign act    = {act_cw, halted, fault, fault_code, instr_count};

    // Hand-written per-state control table
    function automatic logic [18:0] cw(input string s);
        logic lpc, lacc, lrs, lrd, lir, lmar, lmdr, pcm, rfm, am1, am2, mdm, mr, mw;
        logic [1:0] marm, aop;
        {lpc, lacc, lrs, lrd, lir, lmar, lmdr, pcm, rfm, am1, am2, mdm, mr, mw} = '0;
        marm = 2'd0;
        aop  = alu_add;
        case (s)
            "F1":   begin marm = 2'd2; lmar = 1; lpc = 1; end
            "F2", "LDP2": begin mr = 1; mdm = 1; lmdr = 1; end
            "F3":   lir = 1;
            "ADS":  begin lacc = 1; aop = alu_mul; am2 = 1; end
            "BPD":  begin lpc = 1; pcm = 1; lrs = 1; aop = alu_dec; end
            "LDP1", "STP1": lmar = 1;
            "LDP3": begin rfm = 1; lrs = 1; lrd = 1; am1 = 1; aop = alu_sub; end
            "STP2": begin lmdr = 1; lrs = 1; am1 = 1; aop = alu_sub; end
            "STP3": mw = 1;
            default: ;
        endcase
        return {lpc, lacc, lrs, lrd, lir, lmar, lmdr, pcm, rfm, am1, am2, mdm, marm, aop, mr, mw};
    endfunction

    task automatic ex(input string n, input int cnt, input logic h = 1'b0,
                      input logic f = 1'b0, input logic [1:0] fc = 2'd0);
        exp_t e;
        e.name = n;
        e.v    = {cw(n), h, f, fc, 4'(cnt)};
        exp_q.push_back(e);
    endtask

    task automatic fetch(input int waits, input int cnt);
        ex("F1", cnt);
        for (int i = 0; i <= waits; i++) ex("F2", cnt);
        ex("F3", cnt);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // sel: 0 load_ir, 1 halted, 2 fault, 3 mem_write
    task automatic wait_cond(input string n, input int sel);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = load_ir;
                1: hit = halted;
                2: hit = fault;
                default: hit = mem_write;
            endcase
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: got no event expected event within 80 cycles", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        dq.delete();
        rst_n = 1'b0;
        run = 1'b0;
        opcode = op_ads;
        branch_enable = 1'b0;
        #1;
        chk("rst_ctrl", 32'(act_cw), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_fault_code", 32'(fault_code), 0);
        chk("rst_count", 32'(instr_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Memory responder: each access pops its number of stall cycles (-1 = never)
    initial begin
        int rn, rcur;
        rn = 0;
        rcur = 0;
        mem_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (rn == 0) rcur = (dq.size() != 0) ? dq.pop_front() : 0;
                mem_resp = (rn == rcur);
                rn++;
            end else begin
                mem_resp = 1'b0;
                rn = 0;
            end
        end
    end

    // Monitor: any cycle with active controls, a count change, or a rising halted/fault
    logic [3:0] prev_cnt;
    logic       prev_f, prev_h;
    exp_t       me;
    always @(negedge clk) begin
        if (rst_n) begin
            if (act_cw != 0 || instr_count != prev_cnt || (fault && !prev_f) || (halted && !prev_h)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %h expected nothing", act);
                end else begin
                    me = exp_q.pop_front();
                    if (act !== me.v) begin
                        n_fail++;
                        $display("FAIL %s: got %h expected %h", me.name, act, me.v);
                    end
                end
            end
        end
        prev_cnt = instr_count;
        prev_f   = fault;
        prev_h   = halted;
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        opcode = op_ads;
        branch_enable = 1'b0;

        // program mix: ads, bpd not-taken, bpd taken, ldp, stp, hlt, ads after resume
        do_reset();
        dq = '{2, 0, 0, 0, 1, 0, 0, 0, 3};
        fetch(2, 0); ex("ADS", 0);
        fetch(0, 1);
        fetch(0, 2); ex("BPD", 2);
        fetch(0, 3); ex("LDP1", 3); ex("LDP2", 3); ex("LDP2", 3); ex("LDP3", 3);
        fetch(0, 4); ex("STP1", 4); ex("STP2", 4); ex("STP3", 4);
        fetch(0, 5); ex("HALT", 6, 1'b1);
        fetch(3, 6); ex("ADS", 6); ex("IDLE", 7);
        run = 1'b1;
        wait_cond("ir_ads", 0);  opcode = op_ads;
        wait_cond("ir_bpd0", 0); opcode = op_bpd; branch_enable = 1'b0;
        wait_cond("ir_bpd1", 0); opcode = op_bpd; branch_enable = 1'b1;
        wait_cond("ir_ldp", 0);  opcode = op_ldp;
        wait_cond("ir_stp", 0);  opcode = op_stp;
        wait_cond("ir_hlt", 0);  opcode = op_hlt;
        wait_cond("halt", 1);
        repeat (3) @(negedge clk);
        chk("halt_hold_halted", 32'(halted), 1);
        chk("halt_hold_ctrl", 32'(act_cw), 0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_run0_halted", 32'(halted), 1);
        run = 1'b1;
        wait_cond("ir_resume", 0); opcode = op_ads; run = 1'b0;
        repeat (6) @(negedge clk);
        chk("seg_a_count", 32'(instr_count), 7);

        // 16 ADS instructions wrap the 4-bit counter
        do_reset();
        for (int k = 0; k < 16; k++) begin
            fetch(0, k);
            ex("ADS", k);
        end
        ex("IDLE", 0);
        run = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_cond("ir_wrap", 0);
            if (k == 15) run = 1'b0;
        end
        repeat (5) @(negedge clk);
        chk("wrap_count", 32'(instr_count), 0);

        // reset during STP_3, then illegal opcode from IDLE
        do_reset();
        dq = '{0, -1};
        fetch(0, 0); ex("STP1", 0); ex("STP2", 0); ex("STP3", 0); ex("STP3", 0);
        opcode = op_stp;
        run = 1'b1;
        wait_cond("stp3", 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("midrst_mem_write", 32'(mem_write), 0);
        chk("midrst_ctrl", 32'(act_cw), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_rst_ctrl", 32'(act_cw), 0);
        dq.delete();
        fetch(0, 0); ex("FAULT", 0, 1'b0, 1'b1, 2'd2);
        opcode = tiny8_opcode'(3'd7);
        run = 1'b1;
        wait_cond("illegal", 2);
        #1;
        chk("illegal_code", 32'(fault_code), 2);

        // LDP_2 timeout after 4 stalled cycles; run toggling in FAULT is ignored
        do_reset();
        dq = '{0, -1};
        fetch(0, 0); ex("LDP1", 0);
        for (int i = 0; i < 4; i++) ex("LDP2", 0);
        ex("FAULT", 0, 1'b0, 1'b1, 2'd1);
        opcode = op_ldp;
        run = 1'b1;
        wait_cond("timeout", 2);
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            @(negedge clk);
        end
        #1;
        chk("fault_sticky", 32'(fault), 1);
        chk("fault_code_timeout", 32'(fault_code), 1);
        chk("fault_ctrl_idle", 32'(act_cw), 0);
        chk("fault_count", 32'(instr_count), 0);

        @(negedge clk);
        #1;
        chk("final_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
